// File: rtl/rob_commit_unit.sv
// ---------------------------------------------------------------------------
// rob_commit_unit
//   Reorder buffer with in-order commit of up to COMMIT_W (1 or 2) entries per
//   cycle. It maintains the retirement RAT, frees superseded physical tags
//   and raises a flush/redirect when the head entry carries an exception or
//   a control-flow redirect.
//
// Ports
//   CLK, RESET            clock; asynchronous active-high reset
//   FREEZE                holds commit (allocation and completion continue)
//   alloc_*               allocate a new tail entry; alloc_tag = tail index,
//                         alloc_full = ROB holds 2^ROB_AW entries
//   cmp_*                 completion writeback addressed by ROB tag
//   free_valid/free_id    registered per-slot freed physical tag (slot 0 LSBs)
//   flush_OUT, copyRetRat_OUT, redirect_valid, redirect_pc
//                         registered one-cycle flush/redirect pulse
//   retRat_OUT            retirement RAT, arch register 0 at the MSBs
//   rob_empty             no entries outstanding
// ---------------------------------------------------------------------------
module rob_commit_unit #(
  parameter int          ROB_AW     = 4,
  parameter int          COMMIT_W   = 2,
  parameter int          PHYS_W     = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FREEZE,
  input  logic                       alloc_req,
  input  logic                       alloc_has_dst,
  input  logic [4:0]                 alloc_arch_dst,
  input  logic [PHYS_W-1:0]          alloc_phys_dst,
  output logic [ROB_AW-1:0]          alloc_tag,
  output logic                       alloc_full,
  input  logic                       cmp_valid,
  input  logic [ROB_AW-1:0]          cmp_tag,
  input  logic                       cmp_exc,
  input  logic                       cmp_redirect,
  input  logic [31:0]                cmp_target,
  output logic [COMMIT_W-1:0]        free_valid,
  output logic [COMMIT_W*PHYS_W-1:0] free_id,
  output logic                       flush_OUT,
  output logic                       copyRetRat_OUT,
  output logic                       redirect_valid,
  output logic [31:0]                redirect_pc,
  output logic [32*PHYS_W-1:0]       retRat_OUT,
  output logic                       rob_empty
);

  localparam int              DEPTH      = 1 << ROB_AW;
  localparam logic [ROB_AW:0] FULL_COUNT = (ROB_AW+1)'(DEPTH);

  // Entry storage
  logic [DEPTH-1:0]    valid_r, done_r, exc_r, redir_r, hasDst_r;
  logic [31:0]         target_r [DEPTH];
  logic [4:0]          arch_r   [DEPTH];
  logic [PHYS_W-1:0]   phys_r   [DEPTH];
  logic [ROB_AW-1:0]   head_r, tail_r;
  logic [ROB_AW:0]     count_r;

  // Retirement RAT
  logic [PHYS_W-1:0]   retRat_r [32];
  logic [31:0]         retRatValid_r;

  // Registered commit outputs (always two slots wide internally)
  logic [1:0]          freeValid_r;
  logic [2*PHYS_W-1:0] freeId_r;
  logic                flush_r, copyRetRat_r, redirValid_r;
  logic [31:0]         redirPc_r;

  // Commit decode
  logic [ROB_AW-1:0]   head1_s;
  logic                slot0_s, slot1_s, slot0Exc_s, flushDo_s;
  logic                write0_s, write1_s, old0Valid_s, old1Valid_s;
  logic [PHYS_W-1:0]   old0Phys_s, old1Phys_s;
  logic [1:0]          commitCnt_s;
  logic                allocDo_s, cmpDo_s;

  // Decide which slots retire this cycle and what mappings they displace
  always_comb begin
    head1_s     = head_r + ROB_AW'(1);
    slot0_s     = valid_r[head_r] && done_r[head_r] && !FREEZE;
    slot0Exc_s  = slot0_s && exc_r[head_r];
    flushDo_s   = slot0_s && (exc_r[head_r] || redir_r[head_r]);
    // Slot 1 only pairs with a clean slot 0; any flush ends the commit group.
    slot1_s     = (COMMIT_W == 2) && slot0_s && !exc_r[head_r] && !redir_r[head_r]
                  && valid_r[head1_s] && done_r[head1_s]
                  && !exc_r[head1_s] && !redir_r[head1_s];
    write0_s    = slot0_s && !exc_r[head_r] && hasDst_r[head_r];
    write1_s    = slot1_s && hasDst_r[head1_s];
    old0Phys_s  = retRat_r[arch_r[head_r]];
    old0Valid_s = retRatValid_r[arch_r[head_r]];
    // Same arch register in both slots: slot 1 displaces slot 0's new mapping.
    if (write0_s && (arch_r[head1_s] == arch_r[head_r])) begin
      old1Phys_s  = phys_r[head_r];
      old1Valid_s = 1'b1;
    end else begin
      old1Phys_s  = retRat_r[arch_r[head1_s]];
      old1Valid_s = retRatValid_r[arch_r[head1_s]];
    end
    commitCnt_s = {1'b0, slot0_s} + {1'b0, slot1_s};
    allocDo_s   = alloc_req && !alloc_full && !flush_OUT;
    cmpDo_s     = cmp_valid && valid_r[cmp_tag] && !flush_OUT;
  end

  // ROB state, retirement RAT and registered commit/flush outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_r       <= {DEPTH{1'b0}};
      done_r        <= {DEPTH{1'b0}};
      exc_r         <= {DEPTH{1'b0}};
      redir_r       <= {DEPTH{1'b0}};
      hasDst_r      <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        target_r[i] <= 32'h0000_0000;
        arch_r[i]   <= 5'd0;
        phys_r[i]   <= {PHYS_W{1'b0}};
      end
      head_r        <= {ROB_AW{1'b0}};
      tail_r        <= {ROB_AW{1'b0}};
      count_r       <= {(ROB_AW+1){1'b0}};
      for (int a = 0; a < 32; a++) begin
        retRat_r[a] <= {PHYS_W{1'b0}};
      end
      retRatValid_r <= 32'h0000_0000;
      freeValid_r   <= 2'b00;
      freeId_r      <= {(2*PHYS_W){1'b0}};
      flush_r       <= 1'b0;
      copyRetRat_r  <= 1'b0;
      redirValid_r  <= 1'b0;
      redirPc_r     <= 32'h0000_0000;
    end else begin
      freeValid_r  <= 2'b00;
      flush_r      <= 1'b0;
      copyRetRat_r <= 1'b0;
      redirValid_r <= 1'b0;

      if (allocDo_s) begin
        valid_r[tail_r]  <= 1'b1;
        done_r[tail_r]   <= 1'b0;
        exc_r[tail_r]    <= 1'b0;
        redir_r[tail_r]  <= 1'b0;
        hasDst_r[tail_r] <= alloc_has_dst;
        arch_r[tail_r]   <= alloc_arch_dst;
        phys_r[tail_r]   <= alloc_phys_dst;
        tail_r           <= tail_r + ROB_AW'(1);
      end

      if (cmpDo_s) begin
        done_r[cmp_tag]   <= 1'b1;
        exc_r[cmp_tag]    <= cmp_exc;
        redir_r[cmp_tag]  <= cmp_redirect;
        target_r[cmp_tag] <= cmp_target;
      end

      if (slot0_s) begin
        valid_r[head_r] <= 1'b0;
        if (write0_s) begin
          retRat_r[arch_r[head_r]]      <= phys_r[head_r];
          retRatValid_r[arch_r[head_r]] <= 1'b1;
          freeValid_r[0]                <= old0Valid_s;
          freeId_r[PHYS_W-1:0]          <= old0Phys_s;
        end
      end

      // Slot 1 RAT write comes last so it wins on a shared arch register.
      if (slot1_s) begin
        valid_r[head1_s] <= 1'b0;
        if (write1_s) begin
          retRat_r[arch_r[head1_s]]      <= phys_r[head1_s];
          retRatValid_r[arch_r[head1_s]] <= 1'b1;
          freeValid_r[1]                 <= old1Valid_s;
          freeId_r[2*PHYS_W-1:PHYS_W]    <= old1Phys_s;
        end
      end

      head_r  <= head_r + ROB_AW'(commitCnt_s);
      count_r <= count_r + (ROB_AW+1)'(allocDo_s) - (ROB_AW+1)'(commitCnt_s);

      // A flush discards every younger entry, including one allocated now.
      if (flushDo_s) begin
        valid_r      <= {DEPTH{1'b0}};
        head_r       <= {ROB_AW{1'b0}};
        tail_r       <= {ROB_AW{1'b0}};
        count_r      <= {(ROB_AW+1){1'b0}};
        flush_r      <= 1'b1;
        copyRetRat_r <= 1'b1;
        redirValid_r <= 1'b1;
        redirPc_r    <= slot0Exc_s ? EXC_VECTOR : target_r[head_r];
      end
    end
  end

  assign alloc_tag      = tail_r;
  assign alloc_full     = (count_r == FULL_COUNT);
  assign rob_empty      = (count_r == {(ROB_AW+1){1'b0}});
  assign free_valid     = freeValid_r[COMMIT_W-1:0];
  assign free_id        = freeId_r[COMMIT_W*PHYS_W-1:0];
  assign flush_OUT      = flush_r;
  assign copyRetRat_OUT = copyRetRat_r;
  assign redirect_valid = redirValid_r;
  assign redirect_pc    = redirPc_r;

  for (genvar g = 0; g < 32; g++) begin : gRatOut
    assign retRat_OUT[(31-g)*PHYS_W +: PHYS_W] = retRat_r[g];
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// ---------------------------------------------------------------------------
// tb_rob_commit_unit
//   Directed scenarios followed by random traffic on a 4-entry ROB. A queue
//   based reference model retires entries in program order and keeps its own
//   retirement RAT; DUT outputs are compared after every clock edge.
// ---------------------------------------------------------------------------
module tb_rob_commit_unit;

  localparam int          AW    = 2;
  localparam int          DEPTH = 4;
  localparam int          CW    = 2;
  localparam int          PW    = 6;
  localparam logic [31:0] EXCV  = 32'h0000_0080;

  logic              CLK = 1'b0;
  logic              RESET, FREEZE;
  logic              alloc_req, alloc_has_dst;
  logic [4:0]        alloc_arch_dst;
  logic [PW-1:0]     alloc_phys_dst;
  logic [AW-1:0]     alloc_tag;
  logic              alloc_full;
  logic              cmp_valid;
  logic [AW-1:0]     cmp_tag;
  logic              cmp_exc, cmp_redirect;
  logic [31:0]       cmp_target;
  logic [CW-1:0]     free_valid;
  logic [CW*PW-1:0]  free_id;
  logic              flush_OUT, copyRetRat_OUT, redirect_valid;
  logic [31:0]       redirect_pc;
  logic [32*PW-1:0]  retRat_OUT;
  logic              rob_empty;

  always #5 CLK = ~CLK;

  rob_commit_unit #(.ROB_AW(AW), .COMMIT_W(CW), .PHYS_W(PW), .EXC_VECTOR(EXCV)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
    .alloc_req(alloc_req), .alloc_has_dst(alloc_has_dst),
    .alloc_arch_dst(alloc_arch_dst), .alloc_phys_dst(alloc_phys_dst),
    .alloc_tag(alloc_tag), .alloc_full(alloc_full),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_exc(cmp_exc),
    .cmp_redirect(cmp_redirect), .cmp_target(cmp_target),
    .free_valid(free_valid), .free_id(free_id),
    .flush_OUT(flush_OUT), .copyRetRat_OUT(copyRetRat_OUT),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .retRat_OUT(retRat_OUT), .rob_empty(rob_empty)
  );

  // Reference model: program-order queue of in-flight instructions
  typedef struct {
    int          tag;
    bit          hasDst;
    int          arch;
    int          phys;
    bit          done;
    bit          exc;
    bit          redir;
    logic [31:0] target;
  } ent_t;

  ent_t        q[$];
  int          mRat[32];
  bit          mRatV[32];
  int          mTail;
  bit          mFlush;
  logic [31:0] mRedirPc;
  bit [1:0]    eFree;
  int          eFreeId[2];

  int passCnt  = 0;
  int failCnt  = 0;
  int totalCnt = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] ratOf(input int a);
    return retRat_OUT[(31-a)*PW +: PW];
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) begin
      mRat[i]  = 0;
      mRatV[i] = 1'b0;
    end
    mTail    = 0;
    mFlush   = 1'b0;
    mRedirPc = 32'h0;
    eFree    = 2'b00;
  endtask

  // Advance the model across one clock edge with the given inputs
  task automatic model_step(input bit a, input bit hd, input int ar, input int ph,
                            input bit cv, input int ct, input bit ce, input bit cr,
                            input logic [31:0] tg, input bit fz);
    bit          fullNow, flushNow, fl;
    logic [31:0] pc;
    int          n;
    ent_t        e;
    fullNow  = (q.size() == DEPTH);
    flushNow = mFlush;
    fl       = 1'b0;
    pc       = 32'h0;
    eFree    = 2'b00;
    n        = 0;
    if (!fz && q.size() > 0 && q[0].done) begin
      n = 1;
      if (q.size() > 1 && !q[0].exc && !q[0].redir && q[1].done && !q[1].exc && !q[1].redir)
        n = 2;
    end
    for (int s = 0; s < n; s++) begin
      e = q.pop_front();
      if (e.exc) begin
        fl = 1'b1;
        pc = EXCV;
      end else begin
        if (e.hasDst) begin
          if (mRatV[e.arch]) begin
            eFree[s]   = 1'b1;
            eFreeId[s] = mRat[e.arch];
          end
          mRat[e.arch]  = e.phys;
          mRatV[e.arch] = 1'b1;
        end
        if (e.redir) begin
          fl = 1'b1;
          pc = e.target;
        end
      end
    end
    if (cv && !flushNow) begin
      foreach (q[i]) begin
        if (q[i].tag == ct) begin
          q[i].done   = 1'b1;
          q[i].exc    = ce;
          q[i].redir  = cr;
          q[i].target = tg;
        end
      end
    end
    if (a && !fullNow && !flushNow) begin
      e.tag = mTail; e.hasDst = hd; e.arch = ar; e.phys = ph;
      e.done = 1'b0; e.exc = 1'b0; e.redir = 1'b0; e.target = 32'h0;
      q.push_back(e);
      mTail = (mTail + 1) % DEPTH;
    end
    if (fl) begin
      q.delete();
      mTail    = 0;
      mRedirPc = pc;
    end
    mFlush = fl;
  endtask

  task automatic compare_all();
    logic [32*PW-1:0] expRat;
    for (int a = 0; a < 32; a++) expRat[(31-a)*PW +: PW] = PW'(mRat[a]);
    chk("alloc_tag", alloc_tag, mTail);
    chk("alloc_full", alloc_full, q.size() == DEPTH);
    chk("rob_empty", rob_empty, q.size() == 0);
    chk("flush", flush_OUT, mFlush);
    chk("copyRetRat", copyRetRat_OUT, mFlush);
    chk("redirect_valid", redirect_valid, mFlush);
    if (mFlush) chk("redirect_pc", redirect_pc, mRedirPc);
    chk("free_valid", free_valid, eFree);
    if (eFree[0]) chk("free_id0", free_id[PW-1:0], eFreeId[0]);
    if (eFree[1]) chk("free_id1", free_id[2*PW-1:PW], eFreeId[1]);
    chk("retRat", retRat_OUT, expRat);
  endtask

  task automatic cyc(input bit a, input bit hd, input int ar, input int ph,
                     input bit cv, input int ct, input bit ce, input bit cr,
                     input logic [31:0] tg, input bit fz);
    alloc_req = a; alloc_has_dst = hd; alloc_arch_dst = 5'(ar); alloc_phys_dst = PW'(ph);
    cmp_valid = cv; cmp_tag = AW'(ct); cmp_exc = ce; cmp_redirect = cr; cmp_target = tg;
    FREEZE = fz;
    model_step(a, hd, ar, ph, cv, ct, ce, cr, tg, fz);
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic alloc(input int ar, input int ph);
    cyc(1'b1, 1'b1, ar, ph, 1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic cmpl(input int ct, input bit ce, input bit cr, input logic [31:0] tg, input bit fz);
    cyc(1'b0, 1'b0, 0, 0, 1'b1, ct, ce, cr, tg, fz);
  endtask

  task automatic idle(input bit fz);
    cyc(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 32'h0, fz);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    alloc_req = 1'b0; cmp_valid = 1'b0; FREEZE = 1'b0;
    #1;
    chk("rst_rob_empty", rob_empty, 1'b1);
    chk("rst_alloc_full", alloc_full, 1'b0);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_flush", flush_OUT, 1'b0);
    chk("rst_free_valid", free_valid, 2'b00);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_retRat", retRat_OUT, 0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  initial begin
    alloc_req = 1'b0; alloc_has_dst = 1'b0; alloc_arch_dst = 5'd0; alloc_phys_dst = '0;
    cmp_valid = 1'b0; cmp_tag = '0; cmp_exc = 1'b0; cmp_redirect = 1'b0;
    cmp_target = 32'h0; FREEZE = 1'b0;
    do_reset();

    // Two first mappings retire together
    alloc(5, 10);
    alloc(6, 11);
    cmpl(1, 1'b0, 1'b0, 32'h0, 1'b0);
    cmpl(0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    chk("r032_rat5", ratOf(5), 10);
    chk("r032_rat6", ratOf(6), 11);
    chk("r032_free", free_valid, 2'b00);

    // Same arch register in both slots
    alloc(5, 12);
    alloc(5, 13);
    cmpl(3, 1'b0, 1'b0, 32'h0, 1'b0);
    cmpl(2, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    chk("r033_free", free_valid, 2'b11);
    chk("r033_id0", free_id[PW-1:0], 10);
    chk("r033_id1", free_id[2*PW-1:PW], 12);
    chk("r033_rat5", ratOf(5), 13);

    // Exception beats redirect; no RAT write, vector redirect
    alloc(7, 20);
    cmpl(0, 1'b1, 1'b1, 32'h0000_2000, 1'b0);
    idle(1'b0);
    chk("r035_flush", flush_OUT, 1'b1);
    chk("r035_pc", redirect_pc, EXCV);
    chk("r035_free", free_valid, 2'b00);
    chk("r035_rat7", ratOf(7), 0);
    idle(1'b0);
    chk("r035_pulse_end", flush_OUT, 1'b0);

    // Completions recorded while frozen, commit after release
    alloc(8, 30);
    cmpl(0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk("r037_no_free", free_valid, 2'b00);
      chk("r037_not_empty", rob_empty, 1'b0);
    end
    idle(1'b0);
    chk("r037_commit", rob_empty, 1'b1);
    chk("r037_rat8", ratOf(8), 30);

    // Fill, overflow attempt, redirect flush of three younger entries
    alloc(1, 1);
    alloc(2, 2);
    alloc(3, 3);
    alloc(4, 4);
    chk("r036_full", alloc_full, 1'b1);
    alloc(9, 9);
    chk("r036_still_full", alloc_full, 1'b1);
    cmpl(1, 1'b0, 1'b1, 32'h0000_1000, 1'b0);
    idle(1'b0);
    chk("r034_flush", flush_OUT, 1'b1);
    chk("r034_copy", copyRetRat_OUT, 1'b1);
    chk("r034_pc", redirect_pc, 32'h0000_1000);
    chk("r034_empty", rob_empty, 1'b1);
    chk("r034_tag", alloc_tag, 0);
    chk("r034_rat1", ratOf(1), 1);
    alloc(10, 10);
    chk("r034_pulse_end", flush_OUT, 1'b0);
    chk("r034_alloc_blocked", rob_empty, 1'b1);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      bit          a, hd, cv, ce, cr, fz;
      int          ar, ph, ct;
      logic [31:0] tg;
      a  = ($urandom_range(0, 3) != 0);
      hd = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 7);
      ph = $urandom_range(0, 63);
      cv = ($urandom_range(0, 9) < 7);
      if (q.size() > 0 && $urandom_range(0, 9) < 8)
        ct = q[$urandom_range(0, q.size() - 1)].tag;
      else
        ct = $urandom_range(0, DEPTH - 1);
      ce = ($urandom_range(0, 19) == 0);
      cr = ($urandom_range(0, 9) == 0);
      tg = $urandom;
      fz = ($urandom_range(0, 7) == 0);
      cyc(a, hd, ar, ph, cv, ct, ce, cr, tg, fz);
    end

    // Reset in the middle of a pending commit
    alloc(11, 40);
    cmpl(mTail == 0 ? DEPTH - 1 : mTail - 1, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    do_reset();
    for (int k = 0; k < 3; k++) idle(1'b0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
